// File: rtl/fifo_pkg.sv
// Shared helpers for the streaming FIFO family: sizing functions for the
// occupancy count and the storage pointers.
package fifo_pkg;

  // Width able to hold every value from 0 up to and including depth.
  function automatic int unsigned cw(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  // Pointer width for a modulo-depth index; never narrower than one bit.
  function automatic int unsigned ptr_w(input int unsigned depth);
    int unsigned w;
    w = $clog2(depth);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/streaming_fifo_wm_if.sv
// AXI-Stream style handshake bundle (TDATA/TVALID/TREADY).
// master: drives TDATA/TVALID, receives TREADY; slave: the reverse.
interface streaming_fifo_wm_if #(
  parameter int unsigned WIDTH = 8
);
  logic [WIDTH-1:0] TDATA;
  logic             TVALID;
  logic             TREADY;

  modport master (output TDATA, output TVALID, input TREADY);
  modport slave  (input TDATA, input TVALID, output TREADY);
endinterface

// File: rtl/fifo_wrap_ptr.sv
// Modulo-DEPTH pointer with increment enable and synchronous reset.
// Ports: clk, rst (sync, active-high), inc (advance by one), ptr (current index).
module fifo_wrap_ptr
  import fifo_pkg::*;
#(
  parameter  int unsigned DEPTH = 16,
  localparam int unsigned PW    = ptr_w(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inc,
  output logic [PW-1:0] ptr
);

  logic [PW-1:0] ptr_q;
  logic [PW-1:0] ptr_d;

  // Wrap explicitly at DEPTH-1 so non-power-of-two depths work.
  always_comb begin
    ptr_d = ptr_q;
    if (inc) begin
      if (ptr_q == PW'(DEPTH - 1)) ptr_d = '0;
      else                         ptr_d = ptr_q + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/streaming_fifo_wm.sv
// First-word fall-through AXI-Stream FIFO of arbitrary depth with occupancy
// count, registered almost-full/almost-empty flags and a clearable
// high-water mark.
// Ports: ap_clk, ap_rst (sync, active-high); in0_V (slave stream in);
// out_V (master stream out); count, maxcount, maxcount_clr;
// almost_full, almost_empty.
module streaming_fifo_wm
  import fifo_pkg::*;
#(
  parameter  int unsigned WIDTH     = 8,
  parameter  int unsigned DEPTH     = 16384,
  parameter  int unsigned AF_THRESH = DEPTH - 2,
  parameter  int unsigned AE_THRESH = 2,
  localparam int unsigned CW        = cw(DEPTH)
) (
  input  logic                ap_clk,
  input  logic                ap_rst,
  streaming_fifo_wm_if.slave  in0_V,
  streaming_fifo_wm_if.master out_V,
  output logic [CW-1:0]       count,
  output logic [CW-1:0]       maxcount,
  input  logic                maxcount_clr,
  output logic                almost_full,
  output logic                almost_empty
);

  localparam int unsigned PW = ptr_w(DEPTH);

  typedef struct packed {
    logic [WIDTH-1:0] tdata;
  } beat_t;

  beat_t         mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  logic [CW-1:0] count_q,    count_d;
  logic [CW-1:0] maxcount_q, maxcount_d;
  logic          af_q,       af_d;
  logic          ae_q,       ae_d;
  logic          rdy_q,      rdy_d;
  logic          vld_q,      vld_d;
  logic          push;
  logic          pop;

  // Ready/valid come from flops only, so no path from out_V.TREADY to
  // in0_V.TREADY; a full FIFO accepts again only after a pop has landed.
  assign push = in0_V.TVALID & rdy_q;
  assign pop  = vld_q & out_V.TREADY;

  fifo_wrap_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
    .clk (ap_clk),
    .rst (ap_rst),
    .inc (push),
    .ptr (wr_ptr)
  );

  fifo_wrap_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
    .clk (ap_clk),
    .rst (ap_rst),
    .inc (pop),
    .ptr (rd_ptr)
  );

  // Next occupancy and every status flop derived from it.
  always_comb begin
    count_d    = count_q;
    maxcount_d = maxcount_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    if (maxcount_clr)               maxcount_d = count_d;
    else if (count_d > maxcount_q)  maxcount_d = count_d;
    af_d  = (count_d >= CW'(AF_THRESH));
    ae_d  = (count_d <= CW'(AE_THRESH));
    rdy_d = (count_d != CW'(DEPTH));
    vld_d = (count_d != '0);
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      count_q    <= '0;
      maxcount_q <= '0;
      af_q       <= 1'b0;
      ae_q       <= 1'b1;
      rdy_q      <= 1'b1;
      vld_q      <= 1'b0;
    end else begin
      count_q    <= count_d;
      maxcount_q <= maxcount_d;
      af_q       <= af_d;
      ae_q       <= ae_d;
      rdy_q      <= rdy_d;
      vld_q      <= vld_d;
    end
  end

  // Storage is never reset; validity is tracked by count alone.
  always_ff @(posedge ap_clk) begin
    if (push) mem[wr_ptr] <= beat_t'(in0_V.TDATA);
  end

  assign in0_V.TREADY = rdy_q;
  assign out_V.TVALID = vld_q;
  assign out_V.TDATA  = mem[rd_ptr].tdata;
  assign count        = count_q;
  assign maxcount     = maxcount_q;
  assign almost_full  = af_q;
  assign almost_empty = ae_q;

endmodule

// File: tb/tb_streaming_fifo_wm.sv
// Directed bench for streaming_fifo_wm at DEPTH=5, AF_THRESH=4, AE_THRESH=1.
module tb_streaming_fifo_wm;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned DEPTH = 5;
  localparam int unsigned CW    = 3;

  logic          ap_clk = 1'b0;
  logic          ap_rst;
  logic [CW-1:0] count;
  logic [CW-1:0] maxcount;
  logic          maxcount_clr;
  logic          almost_full;
  logic          almost_empty;

  int tests = 0;
  int fails = 0;

  streaming_fifo_wm_if #(.WIDTH(WIDTH)) in0_V ();
  streaming_fifo_wm_if #(.WIDTH(WIDTH)) out_V ();

  streaming_fifo_wm #(
    .WIDTH     (WIDTH),
    .DEPTH     (DEPTH),
    .AF_THRESH (4),
    .AE_THRESH (1)
  ) dut (
    .ap_clk       (ap_clk),
    .ap_rst       (ap_rst),
    .in0_V        (in0_V),
    .out_V        (out_V),
    .count        (count),
    .maxcount     (maxcount),
    .maxcount_clr (maxcount_clr),
    .almost_full  (almost_full),
    .almost_empty (almost_empty)
  );

  always #5 ap_clk = ~ap_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one edge and settle away from it.
  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  initial begin
    int mcount;
    int pushed;
    int popped;
    logic exp_push;
    logic exp_pop;

    ap_rst          = 1'b1;
    maxcount_clr    = 1'b0;
    in0_V.TVALID    = 1'b0;
    in0_V.TDATA     = '0;
    out_V.TREADY    = 1'b0;
    tick();
    tick();
    ap_rst = 1'b0;

    // Reset state
    check("rst_count", 32'(count), 0);
    check("rst_tvalid", 32'(out_V.TVALID), 0);
    check("rst_tready", 32'(in0_V.TREADY), 1);
    check("rst_ae", 32'(almost_empty), 1);
    check("rst_af", 32'(almost_full), 0);
    check("rst_max", 32'(maxcount), 0);

    // Fill to full with downstream stalled
    for (int i = 0; i < 5; i++) begin
      in0_V.TVALID = 1'b1;
      in0_V.TDATA  = 8'(8'h11 + i);
      tick();
      check("fill_count", 32'(count), 32'(i + 1));
      check("fill_af", 32'(almost_full), (i + 1 >= 4) ? 1 : 0);
      check("fill_ae", 32'(almost_empty), (i + 1 <= 1) ? 1 : 0);
    end
    check("full_tready", 32'(in0_V.TREADY), 0);
    in0_V.TDATA = 8'h16;
    tick();
    check("held6_count", 32'(count), 5);
    check("held6_tready", 32'(in0_V.TREADY), 0);
    check("held6_head", 32'(out_V.TDATA), 32'h11);
    check("fill_max", 32'(maxcount), 5);

    // Drain and verify order; the held 0x16 must not appear
    in0_V.TVALID = 1'b0;
    out_V.TREADY = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("drain_tvalid", 32'(out_V.TVALID), 1);
      check("drain_data", 32'(out_V.TDATA), 32'(8'h11 + i));
      tick();
    end
    check("drain_count", 32'(count), 0);
    check("drain_tvalid0", 32'(out_V.TVALID), 0);

    // Wrap-around with random downstream ready, checked against a small model
    mcount = 0;
    pushed = 0;
    popped = 0;
    for (int cyc = 0; cyc < 200 && popped < 12; cyc++) begin
      in0_V.TVALID = (pushed < 12);
      in0_V.TDATA  = 8'(pushed);
      out_V.TREADY = 1'($urandom_range(0, 1));
      #1;
      check("wrap_tready", 32'(in0_V.TREADY), (mcount != 5) ? 1 : 0);
      check("wrap_tvalid", 32'(out_V.TVALID), (mcount != 0) ? 1 : 0);
      exp_push = (pushed < 12) && (mcount != 5);
      exp_pop  = (mcount != 0) && out_V.TREADY;
      if (exp_pop) check("wrap_data", 32'(out_V.TDATA), 32'(popped));
      tick();
      if (exp_push) begin pushed++; mcount++; end
      if (exp_pop)  begin popped++; mcount--; end
      check("wrap_count", 32'(count), 32'(mcount));
      check("wrap_le5", 32'(count <= 3'd5), 1);
    end
    check("wrap_popped", 32'(popped), 12);
    in0_V.TVALID = 1'b0;
    out_V.TREADY = 1'b0;

    // Simultaneous push/pop at count 3; maxcount stays at 5
    for (int i = 0; i < 3; i++) begin
      in0_V.TVALID = 1'b1;
      in0_V.TDATA  = 8'(8'h30 + i);
      tick();
    end
    check("sim_pre_count", 32'(count), 3);
    out_V.TREADY = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in0_V.TDATA = 8'(8'h33 + i);
      check("sim_head", 32'(out_V.TDATA), 32'(8'h30 + i));
      tick();
      check("sim_count", 32'(count), 3);
    end
    check("sim_max", 32'(maxcount), 5);

    // Full plus pop: only the pop happens first, then push and pop together
    out_V.TREADY = 1'b0;
    in0_V.TDATA  = 8'h3d;
    tick();
    in0_V.TDATA  = 8'h3e;
    tick();
    check("fp_full", 32'(count), 5);
    in0_V.TDATA  = 8'h40;
    out_V.TREADY = 1'b1;
    #1;
    check("fp_tready_full", 32'(in0_V.TREADY), 0);
    tick();
    check("fp_c1_count", 32'(count), 4);
    check("fp_c1_head", 32'(out_V.TDATA), 32'h3b);
    check("fp_c1_tready", 32'(in0_V.TREADY), 1);
    tick();
    check("fp_c2_count", 32'(count), 4);
    in0_V.TVALID = 1'b0;
    for (int i = 0; i < 4; i++) begin
      logic [7:0] exp_tab [4];
      exp_tab = '{8'h3c, 8'h3d, 8'h3e, 8'h40};
      check("fp_drain", 32'(out_V.TDATA), 32'(exp_tab[i]));
      tick();
    end
    check("fp_empty", 32'(count), 0);
    out_V.TREADY = 1'b0;

    // Watermark: clear at empty, rise to 4, drain to 1, clear while pushing
    maxcount_clr = 1'b1;
    tick();
    maxcount_clr = 1'b0;
    check("wm_clr0", 32'(maxcount), 0);
    in0_V.TVALID = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in0_V.TDATA = 8'(8'h50 + i);
      tick();
    end
    check("wm_max4", 32'(maxcount), 4);
    check("wm_af4", 32'(almost_full), 1);
    in0_V.TVALID = 1'b0;
    out_V.TREADY = 1'b1;
    tick();
    tick();
    tick();
    out_V.TREADY = 1'b0;
    check("wm_count1", 32'(count), 1);
    check("wm_ae1", 32'(almost_empty), 1);
    check("wm_max_hold", 32'(maxcount), 4);
    maxcount_clr = 1'b1;
    in0_V.TVALID = 1'b1;
    in0_V.TDATA  = 8'h60;
    tick();
    maxcount_clr = 1'b0;
    check("wm_clr_count", 32'(count), 2);
    check("wm_clr_max", 32'(maxcount), 2);
    check("wm_ae2", 32'(almost_empty), 0);

    // Reset mid-stream at count 3 flushes everything
    in0_V.TDATA = 8'h61;
    tick();
    in0_V.TVALID = 1'b0;
    check("mr_pre", 32'(count), 3);
    ap_rst = 1'b1;
    tick();
    ap_rst = 1'b0;
    check("mr_count", 32'(count), 0);
    check("mr_tvalid", 32'(out_V.TVALID), 0);
    check("mr_tready", 32'(in0_V.TREADY), 1);
    check("mr_max", 32'(maxcount), 0);
    check("mr_ae", 32'(almost_empty), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
